// File: rtl/wide_addsub_sequencer_if.sv
// Operand/result handshake bundle for wide_addsub_sequencer.
// The master side supplies operands and accepts results; the slave side is the sequencer.
interface wide_addsub_sequencer_if #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_SLICES = 4
);
  localparam int W = DATA_WIDTH * NUM_SLICES;

  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         SUB;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] S;
  logic         CF;
  logic         OF;
  logic         BUSY;

  modport master (
    output IN_VALID, A, B, SUB, OUT_READY,
    input  IN_READY, OUT_VALID, S, CF, OF, BUSY
  );

  modport slave (
    input  IN_VALID, A, B, SUB, OUT_READY,
    output IN_READY, OUT_VALID, S, CF, OF, BUSY
  );
endinterface

// File: rtl/wide_addsub_sequencer.sv
// Multi-precision add/subtract engine: one DATA_WIDTH-bit ripple-carry adder is
// reused over NUM_SLICES slices, least-significant first, with the carry held in
// a register between slices.
// Optional feature macro: WIDE_ADDSUB_SAT_EN -- clamps the presented result to
// signed saturation on overflow (CF/OF still report the raw values).

// Narrow ripple-carry adder used once per slice.
module ripple_carry_adder #(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout,
  output logic                  ovf
);
  logic [DATA_WIDTH:0] c;

  // Bit-serial carry chain; overflow is carry-in xor carry-out of the MSB.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[DATA_WIDTH];
    ovf  = c[DATA_WIDTH] ^ c[DATA_WIDTH-1];
  end
endmodule

module wide_addsub_sequencer #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_SLICES = 4
) (
  input logic                    CLK,
  input logic                    RST,
  wide_addsub_sequencer_if.slave bus
);
  localparam int W  = DATA_WIDTH * NUM_SLICES;
  localparam int CW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CW-1:0] LAST       = CW'(NUM_SLICES - 1);
  localparam logic [W-1:0]  SLICE_MASK = W'({DATA_WIDTH{1'b1}});

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            carry_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            sub_q;
  logic [W-1:0]    s_q;
  logic            cf_q;
  logic            of_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;

  logic [31:0]           sh;
  logic [DATA_WIDTH-1:0] add_a;
  logic [DATA_WIDTH-1:0] add_b;
  logic [DATA_WIDTH-1:0] add_sum;
  logic                  add_co;
  logic                  add_of;
  logic [W-1:0]          s_next;

`ifdef WIDE_ADDSUB_SAT_EN
  // Signed saturation value: result sign 1 on overflow means the true value was positive.
  function automatic logic signed [W-1:0] sat_value(input logic res_sign);
    logic signed [W-1:0] v;
    v = res_sign ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
    return v;
  endfunction
`endif

  ripple_carry_adder #(.DATA_WIDTH(DATA_WIDTH)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_co),
    .ovf  (add_of)
  );

  // Select slice k of the latched operands and merge the adder sum back into the result.
  always_comb begin
    sh     = 32'(cnt) * 32'(DATA_WIDTH);
    add_a  = DATA_WIDTH'(a_q >> sh);
    add_b  = DATA_WIDTH'(b_q >> sh) ^ {DATA_WIDTH{sub_q}};
    s_next = (s_q & ~(SLICE_MASK << sh)) | (W'(add_sum) << sh);
`ifdef WIDE_ADDSUB_SAT_EN
    if (cnt == LAST && add_of) begin
      s_next = sat_value(add_sum[DATA_WIDTH-1]);
    end
`endif
  end

  // Control FSM with registered handshake outputs; operand registers are not reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      carry_q     <= 1'b0;
      s_q         <= '0;
      cf_q        <= 1'b0;
      of_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.IN_VALID) begin
            a_q        <= bus.A;
            b_q        <= bus.B;
            sub_q      <= bus.SUB;
            carry_q    <= bus.SUB;
            cnt        <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          s_q     <= s_next;
          carry_q <= add_co;
          if (cnt == LAST) begin
            cf_q        <= add_co;
            of_q        <= add_of;
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.OUT_READY) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.IN_READY  = in_ready_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.BUSY      = busy_q;
  assign bus.S         = s_q;
  assign bus.CF        = cf_q;
  assign bus.OF        = of_q;
endmodule

// File: tb/tb_wide_addsub_sequencer.sv
// Testbench for wide_addsub_sequencer (DATA_WIDTH=4, NUM_SLICES=4, W=16).
// Honors WIDE_ADDSUB_SAT_EN in both the reference model and the literal expectations.
module tb_wide_addsub_sequencer;
  localparam int DW = 4;
  localparam int NS = 4;
  localparam int W  = DW * NS;

  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_err;
  bit   chk_en;

  wide_addsub_sequencer_if #(.DATA_WIDTH(DW), .NUM_SLICES(NS)) bus ();

  wide_addsub_sequencer #(.DATA_WIDTH(DW), .NUM_SLICES(NS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: full-width arithmetic result of one operation.
  task automatic ref_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                            output logic [W-1:0] s, output logic cf, output logic of);
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    cf   = full[W];
    of   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    s    = full[W-1:0];
`ifdef WIDE_ADDSUB_SAT_EN
    if (of) s = full[W-1] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
  endtask

  // Transaction-level model: 0 idle, 1 computing (counts edges), 2 result held.
  int           m_phase;
  int           m_edges;
  logic [W-1:0] m_s;
  logic         m_cf;
  logic         m_of;

  always @(posedge CLK) begin
    if (RST) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (bus.IN_VALID) begin
             ref_result(bus.A, bus.B, bus.SUB, m_s, m_cf, m_of);
             m_edges = 0;
             m_phase = 1;
           end
        1: begin
             m_edges++;
             if (m_edges == NS) m_phase = 2;
           end
        default: if (bus.OUT_READY) m_phase = 0;
      endcase
    end
  end

  // Cycle compare against the model, away from the active edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("in_ready",  {31'b0, bus.IN_READY},  {31'b0, m_phase == 0});
      check("out_valid", {31'b0, bus.OUT_VALID}, {31'b0, m_phase == 2});
      check("busy",      {31'b0, bus.BUSY},      {31'b0, m_phase != 0});
      if (m_phase == 2) begin
        check("model_s",  {16'b0, bus.S},  {16'b0, m_s});
        check("model_cf", {31'b0, bus.CF}, {31'b0, m_cf});
        check("model_of", {31'b0, bus.OF}, {31'b0, m_of});
      end
    end
  end

  // Wait for IN_READY, present one operation, and return after the accept edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int t;
    t = 0;
    while (!bus.IN_READY && t < 40) begin
      @(posedge CLK); #1; t++;
    end
    check("launch_ready", {31'b0, bus.IN_READY}, 32'd1);
    bus.A = a; bus.B = b; bus.SUB = sub; bus.IN_VALID = 1'b1;
    @(posedge CLK); #1;
    bus.IN_VALID = 1'b0;
  endtask

  // Count edges until OUT_VALID, then check latency and the literal result.
  task automatic collect(input string name, input logic [W-1:0] es, input logic ecf,
                         input logic eof, input bit release_it);
    int cyc;
    cyc = 0;
    while (!bus.OUT_VALID && cyc < 20) begin
      @(posedge CLK); #1; cyc++;
    end
    check({name, "_latency"}, cyc, NS);
    check({name, "_s"},  {16'b0, bus.S},  {16'b0, es});
    check({name, "_cf"}, {31'b0, bus.CF}, {31'b0, ecf});
    check({name, "_of"}, {31'b0, bus.OF}, {31'b0, eof});
    if (release_it) begin
      bus.OUT_READY = 1'b1;
      @(posedge CLK); #1;
      bus.OUT_READY = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0] ovf_add_s, ovf_sub_s;
`ifdef WIDE_ADDSUB_SAT_EN
    ovf_add_s = 16'h7FFF; ovf_sub_s = 16'h8000;
`else
    ovf_add_s = 16'h8000; ovf_sub_s = 16'h7FFF;
`endif
    n_cmp = 0; n_err = 0; chk_en = 0; m_phase = 0; m_edges = 0;
    m_s = '0; m_cf = 0; m_of = 0;
    RST = 1'b1;
    bus.IN_VALID = 1'b1; bus.A = 16'h1111; bus.B = 16'h2222; bus.SUB = 1'b0;
    bus.OUT_READY = 1'b0;

    // Reset held two edges with IN_VALID high.
    repeat (2) @(posedge CLK);
    #1;
    check("rst_in_ready",  {31'b0, bus.IN_READY},  32'd1);
    check("rst_out_valid", {31'b0, bus.OUT_VALID}, 32'd0);
    check("rst_busy",      {31'b0, bus.BUSY},      32'd0);
    check("rst_s",         {16'b0, bus.S},         32'h0);
    check("rst_cf",        {31'b0, bus.CF},        32'd0);
    check("rst_of",        {31'b0, bus.OF},        32'd0);
    RST = 1'b0; bus.IN_VALID = 1'b0;
    chk_en = 1;
    @(posedge CLK); #1;
    check("rst_no_accept", {31'b0, bus.IN_READY}, 32'd1);

    // Directed arithmetic vectors.
    launch(16'h00FF, 16'h0001, 1'b0); collect("add_carry", 16'h0100, 1'b0, 1'b0, 1);
    launch(16'hFFFF, 16'h0001, 1'b0); collect("add_wrap",  16'h0000, 1'b1, 1'b0, 1);
    launch(16'h7FFF, 16'h0001, 1'b0); collect("add_ovf",   ovf_add_s, 1'b0, 1'b1, 1);
    launch(16'h0005, 16'h0007, 1'b1); collect("sub_neg",   16'hFFFE, 1'b0, 1'b0, 1);
    launch(16'h8000, 16'h0001, 1'b1); collect("sub_ovf",   ovf_sub_s, 1'b1, 1'b1, 1);

    // Backpressure: hold result while new operands churn.
    launch(16'h1111, 16'h2222, 1'b0); collect("bp_first", 16'h3333, 1'b0, 1'b0, 0);
    bus.IN_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.A = 16'(i * 16'h0101); bus.B = 16'(i * 16'h1010); bus.SUB = i[0];
      @(posedge CLK); #1;
      check("bp_hold_s",     {16'b0, bus.S},        32'h3333);
      check("bp_hold_ready", {31'b0, bus.IN_READY}, 32'd0);
    end
    bus.A = 16'h0003; bus.B = 16'h0004; bus.SUB = 1'b0; bus.OUT_READY = 1'b1;
    @(posedge CLK); #1;
    bus.OUT_READY = 1'b0;
    check("bp_idle_ready", {31'b0, bus.IN_READY}, 32'd1);
    @(posedge CLK); #1;
    bus.IN_VALID = 1'b0;
    collect("bp_next", 16'h0007, 1'b0, 1'b0, 1);

    // Reset during RUN after two slice edges.
    launch(16'hAAAA, 16'h1111, 1'b0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("mid_rst_ready", {31'b0, bus.IN_READY},  32'd1);
    check("mid_rst_valid", {31'b0, bus.OUT_VALID}, 32'd0);
    check("mid_rst_s",     {16'b0, bus.S},         32'h0);
    repeat (6) @(posedge CLK);
    #1;
    check("mid_rst_quiet", {31'b0, bus.OUT_VALID}, 32'd0);
    launch(16'h1234, 16'h4321, 1'b0); collect("after_rst", 16'h5555, 1'b0, 1'b0, 1);

    repeat (3) @(posedge CLK);
    #1;
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wide_addsub_sequencer.md
Name: wide_addsub_sequencer

Overview:
- Multi-precision add/subtract engine that time-multiplexes one ripple_carry_adder instance (DATA_WIDTH bits wide) over NUM_SLICES operand slices.
- Processes least-significant slice first and chains the carry through a register between slices.
- Used wherever a wide add/sub is needed but only a narrow adder is affordable.
- Valid/ready handshakes on both the operand side and the result side.

Parameters:
- DATA_WIDTH, 4: width of the instantiated ripple_carry_adder slice.
- NUM_SLICES, 4: number of slices; total operand width W = DATA_WIDTH*NUM_SLICES; must be at least 1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  operands and SUB are valid.
- IN_READY  output  1  sequencer can accept an operation.
- A  input  W  operand A.
- B  input  W  operand B.
- SUB  input  1  0: A+B; 1: A-B.
- OUT_VALID  output  1  result is valid.
- OUT_READY  input  1  consumer accepts the result.
- S  output  W  result.
- CF  output  1  carry out of the top slice; for SUB, 1 means no borrow.
- OF  output  1  two's-complement overflow of the full W-bit operation.
- BUSY  output  1  high in RUN or DONE.

Behaviour:
- Reset: RST high at an edge forces state IDLE, slice counter 0 and carry register 0. Outputs go to S=0, CF=0, OF=0, OUT_VALID=0, IN_READY=1, BUSY=0. Reset takes priority over every other event, including mid-RUN and DONE; any in-flight result is discarded and never presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - IN_READY=1.
  - On an edge with IN_VALID=1, latch A, B and SUB into internal registers. Set carry register = SUB, counter = 0, go to RUN.
  - Later changes on A, B or SUB do not affect this operation.
- RUN:
  - IN_READY=0.
  - Adder inputs: A slice k; B slice k XOR {DATA_WIDTH{SUB}}; Cin = carry register, where k = counter.
  - Each edge writes the adder sum into S bits [k*DATA_WIDTH +: DATA_WIDTH] and the adder CF into the carry register, then increments the counter.
  - On the edge processing k = NUM_SLICES-1: capture adder CF into CF and adder OF into OF, then go to DONE.
- Latency: OUT_VALID rises exactly NUM_SLICES edges after the acceptance edge.
- Throughput: one operation per NUM_SLICES+2 cycles at best. No overlap of accept and result.
- DONE:
  - OUT_VALID=1.
  - S, CF and OF are held stable while OUT_READY=0, for any duration.
  - On an edge with OUT_READY=1, go to IDLE. OUT_VALID drops and IN_READY rises in the following cycle.
  - IN_VALID is ignored while not in IDLE.
- Counter: width clog2(NUM_SLICES), minimum 1 bit. Never wraps in normal operation; it is reset on accept.
- NUM_SLICES=1: RUN lasts one edge.
- Arithmetic: the result equals (A + (SUB ? ~B : B) + SUB) mod 2^W.
- S may show partially updated slices during RUN. It is defined only while OUT_VALID=1.

Optional Feature:
- Macro: WIDE_ADDSUB_SAT_EN.
- Defined: when the final OF=1, the S presented in DONE is clamped to signed saturation. It becomes 0x7F..F if the result sign bit is 1 (positive overflow), else 0x80..0. CF and OF still report the raw, unclamped values.
- Not defined: S is the raw wrapped result. No saturation logic is synthesized.

Test Plan (DATA_WIDTH=4, NUM_SLICES=4, W=16):
- Reset: hold RST=1 for 2 edges with IN_VALID=1 -> IN_READY=1, OUT_VALID=0, BUSY=0, S=0x0000, CF=0, OF=0; no operation accepted.
- Add: A=0x00FF, B=0x0001, SUB=0 -> S=0x0100, CF=0, OF=0; OUT_VALID rises exactly 4 edges after the accept edge. Also A=0xFFFF, B=0x0001 -> S=0x0000, CF=1, OF=0.
- Signed overflow: A=0x7FFF, B=0x0001, SUB=0 -> CF=0, OF=1, S=0x8000 (0x7FFF with WIDE_ADDSUB_SAT_EN).
- Subtract: A=0x0005, B=0x0007, SUB=1 -> S=0xFFFE, CF=0, OF=0. A=0x8000, B=0x0001, SUB=1 -> OF=1, CF=1, S=0x7FFF (0x8000 with WIDE_ADDSUB_SAT_EN).
- Backpressure: finish an operation, hold OUT_READY=0 for 10 cycles while driving new IN_VALID=1 with changing A/B -> S/CF/OF stable, IN_READY=0, nothing accepted. Set OUT_READY=1 -> IDLE the next cycle, and the new operation is accepted and computed correctly.
- Reset mid-operation: assert RST after 2 RUN edges -> IDLE on that edge, OUT_VALID never asserts for the aborted operation. A following 0x1234+0x4321 yields S=0x5555, CF=0, OF=0.
